// File: rtl/flag_period_monitor_if.sv
// flag_period_monitor_if: divider flag input plus period/lock/error status of flag_period_monitor.
interface flag_period_monitor_if #(parameter int CNT_W = 8);
  logic             clk_flag;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  modport master (output clk_flag, input period, period_vld, locked, err, err_cnt);
  modport slave (input clk_flag, output period, period_vld, locked, err, err_cnt);
endinterface

// File: rtl/flag_period_monitor.sv
// flag_period_monitor: measures flag spacing, declares lock after a run of correct periods, flags errors/loss.
module flag_period_monitor #(
  parameter int EXP_PERIOD = 5,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 20,
  parameter int CNT_W      = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  flag_period_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, r_period, r_err_cnt;
  logic [3:0]       r_mcnt, w_mcnt_nxt, w_mcnt_inc;
  logic             r_period_vld, r_err, w_err_nxt, w_flag, w_match, w_timeout, w_meas;
  assign w_flag     = bus.clk_flag;
  assign w_match    = r_cnt == CNT_W'(EXP_PERIOD);
  assign w_timeout  = !w_flag && r_cnt == CNT_W'(TIMEOUT);
  assign w_meas     = w_flag && r_state != IDLE;
  assign w_mcnt_inc = r_mcnt + 4'd1;
  always_comb begin
    w_state_nxt = r_state;
    w_mcnt_nxt  = r_mcnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: if (w_flag) begin
        w_state_nxt = ACQ;
        w_mcnt_nxt  = '0;
      end
      ACQ: if (w_flag) begin
        w_mcnt_nxt  = w_match ? w_mcnt_inc : '0;
        w_state_nxt = (w_match && w_mcnt_inc == 4'(LOCK_CNT)) ? LOCKED : ACQ;
      end else if (w_timeout) w_state_nxt = IDLE;
      // a flag landing exactly on TIMEOUT takes the mismatch path, never the loss path
      default: if ((w_flag && !w_match) || w_timeout) begin
        w_state_nxt = w_flag ? ACQ : IDLE;
        w_mcnt_nxt  = '0;
        w_err_nxt   = 1'b1;
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_mcnt       <= '0;
      r_cnt        <= '0;
      r_period     <= '0;
      r_period_vld <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mcnt       <= w_mcnt_nxt;
      r_cnt        <= w_flag ? ONE : (r_cnt == CNT_MAX ? r_cnt : r_cnt + ONE);
      r_period_vld <= w_meas;
      r_err        <= w_err_nxt;
      if (w_meas) r_period <= r_cnt;
      if (w_err_nxt && r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + ONE;
    end
  assign bus.period     = r_period;
  assign bus.period_vld = r_period_vld;
  assign bus.locked     = r_state == LOCKED;
  assign bus.err        = r_err;
  assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_flag_period_monitor.sv
// tb_flag_period_monitor: table-driven flag spacings with a per-cycle expectation scoreboard.
module tb_flag_period_monitor;
  typedef struct {
    int         gap;
    logic       vld;
    logic [7:0] per;
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } vec_t;
  typedef struct {
    logic       vld;
    logic [7:0] per;
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } exp_t;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cur_lk = 1'b0;
  logic [7:0] cur_ec = 8'd0;
  logic [7:0] nec;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];
  exp_t       sb[$];
  exp_t       m;
  flag_period_monitor_if #(.CNT_W(8)) bus ();
  flag_period_monitor #(.EXP_PERIOD(5), .LOCK_CNT(4), .TIMEOUT(20), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  function automatic vec_t v(int gap, logic vld, logic [7:0] per, logic lk, logic er, logic [7:0] ec);
    vec_t t;
    t = '{gap, vld, per, lk, er, ec};
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_period"}, 32'(bus.period), 0);
    chk({tag, "_vld"}, 32'(bus.period_vld), 0);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
  endtask
  task automatic step(logic f, logic vld, logic [7:0] per, logic lk, logic er, logic [7:0] ec);
    exp_t x;
    @(negedge sys_clk);
    bus.clk_flag = f;
    x = '{vld, per, lk, er, ec};
    sb.push_back(x);
    cur_lk = lk;
    cur_ec = ec;
  endtask
  task automatic quiet(int n);
    repeat (n) step(1'b0, 1'b0, 8'd0, cur_lk, 1'b0, cur_ec);
  endtask
  task automatic apply(vec_t t);
    quiet(t.gap);
    step(1'b1, t.vld, t.per, t.lk, t.er, t.ec);
  endtask
  always @(posedge sys_clk) begin
    #1;
    if (sb.size() != 0) begin
      m = sb.pop_front();
      checks++;
      if (bus.period_vld !== m.vld || (m.vld && bus.period !== m.per) || bus.locked !== m.lk ||
          bus.err !== m.er || bus.err_cnt !== m.ec) begin
        errors++;
        $display("FAIL out @%0t: vld/period/locked/err/err_cnt got %b/%0d/%b/%b/%0d want %b/%0d/%b/%b/%0d",
                 $time, bus.period_vld, bus.period, bus.locked, bus.err, bus.err_cnt,
                 m.vld, m.per, m.lk, m.er, m.ec);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.clk_flag = 1'b0;
    tbl.push_back(v(2, 0, 0, 0, 0, 0));
    repeat (3) tbl.push_back(v(4, 1, 5, 0, 0, 0));
    repeat (2) tbl.push_back(v(4, 1, 5, 1, 0, 0));
    tbl.push_back(v(6, 1, 7, 0, 1, 1));
    repeat (3) tbl.push_back(v(4, 1, 5, 0, 0, 1));
    tbl.push_back(v(4, 1, 5, 1, 0, 1));
    tbl.push_back(v(2, 1, 3, 0, 1, 2));
    repeat (2) tbl.push_back(v(4, 1, 5, 0, 0, 2));
    tbl.push_back(v(2, 1, 3, 0, 0, 2));
    repeat (3) tbl.push_back(v(4, 1, 5, 0, 0, 2));
    repeat (2) tbl.push_back(v(4, 1, 5, 1, 0, 2));
    tbl.push_back(v(0, 1, 1, 0, 1, 3));
    repeat (8) tbl.push_back(v(0, 1, 1, 0, 0, 3));
    tbl.push_back(v(30, 0, 0, 0, 0, 3));
    repeat (3) tbl.push_back(v(4, 1, 5, 0, 0, 3));
    tbl.push_back(v(4, 1, 5, 1, 0, 3));
    tbl.push_back(v(19, 1, 20, 0, 1, 4));
    repeat (3) tbl.push_back(v(4, 1, 5, 0, 0, 4));
    tbl.push_back(v(4, 1, 5, 1, 0, 4));
    #2;
    chk_zero("rst");
    repeat (3) begin
      @(negedge sys_clk);
      bus.clk_flag = ~bus.clk_flag;
      chk_zero("rst_hold");
    end
    @(negedge sys_clk);
    bus.clk_flag = 1'b0;
    sys_rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i]);
    quiet(19);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd5);
    quiet(10);
    apply(v(3, 0, 0, 0, 0, 5));
    apply(v(4, 1, 5, 0, 0, 5));
    repeat (2) apply(v(4, 1, 5, 0, 0, 5));
    apply(v(4, 1, 5, 1, 0, 5));
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) begin
      @(negedge sys_clk);
      bus.clk_flag = ~bus.clk_flag;
      chk_zero("async_hold");
    end
    @(negedge sys_clk);
    bus.clk_flag = 1'b0;
    sys_rst_n = 1'b1;
    cur_lk = 1'b0;
    cur_ec = 8'd0;
    for (int i = 0; i < 6; i++) apply(tbl[i]);
    for (int k = 0; k < 260; k++) begin
      nec = (cur_ec == 8'hff) ? 8'hff : cur_ec + 8'd1;
      apply(v(2, 1, 3, 0, 1, nec));
      repeat (3) apply(v(4, 1, 5, 0, 0, nec));
      apply(v(4, 1, 5, 1, 0, nec));
    end
    @(posedge sys_clk);
    #2;
    chk("err_cnt_sat", 32'(bus.err_cnt), 255);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
